// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: converts (x, y) into an angle in 1/256 degree
// and an uncompensated magnitude, one micro-rotation per clock.
module cordic_vectoring #(
    parameter int W    = 16,
    parameter int ITER = 13,
    parameter int IW   = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x_in,
    input  logic [W-1:0]  y_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] mag_out,
    output logic [IW-1:0] angle_out
);

    localparam int CW = $clog2(ITER);
    localparam logic signed [IW-1:0] Z_90 = IW'(23040);

    // arctan(2^-i) in degrees, Q7.8
    localparam logic [15:0] ATAN_TBL [ITER] = '{
        16'd11520, 16'd6801, 16'd3593, 16'd1824, 16'd916, 16'd458, 16'd229,
        16'd115,   16'd57,   16'd29,   16'd14,   16'd7,   16'd4
    };

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         iter_q, iter_d;
    logic signed [IW-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic                  zero_q, zero_d;
    logic                  out_valid_q, out_valid_d;
    logic [IW-1:0]         mag_q, mag_d, angle_q, angle_d;

    logic signed [IW-1:0]  x_ext, y_ext;
    logic signed [IW-1:0]  x_sh, y_sh, atan_ext;
    logic signed [IW-1:0]  x_step, y_step, z_step;

    assign x_ext = {{(IW-W){x_in[W-1]}}, x_in};
    assign y_ext = {{(IW-W){y_in[W-1]}}, y_in};

    // Both updates use the pre-edge x and y.
    always_comb begin
        x_sh     = x_q >>> iter_q;
        y_sh     = y_q >>> iter_q;
        atan_ext = {{(IW-16){1'b0}}, ATAN_TBL[iter_q]};
        if (y_q[IW-1]) begin
            x_step = x_q - y_sh;
            y_step = y_q + x_sh;
            z_step = z_q - atan_ext;
        end else begin
            x_step = x_q + y_sh;
            y_step = y_q - x_sh;
            z_step = z_q + atan_ext;
        end
    end

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        mag_d       = mag_q;
        angle_d     = angle_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_ITER;
                    iter_d  = '0;
                    zero_d  = (x_in == '0) && (y_in == '0);
                    // Pre-rotate left-half-plane vectors by +/-90 degrees.
                    if (!x_ext[IW-1]) begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end else if (!y_ext[IW-1]) begin
                        x_d = y_ext;
                        y_d = -x_ext;
                        z_d = Z_90;
                    end else begin
                        x_d = -y_ext;
                        y_d = x_ext;
                        z_d = -Z_90;
                    end
                end
            end
            S_ITER: begin
                x_d = x_step;
                y_d = y_step;
                z_d = z_step;
                if (iter_q == CW'(ITER - 1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    mag_d       = x_step;
                    angle_d     = zero_q ? '0 : z_step;
                end else begin
                    iter_d = iter_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            iter_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            mag_q       <= '0;
            angle_q     <= '0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            mag_q       <= mag_d;
            angle_q     <= angle_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign mag_out   = mag_q;
    assign angle_out = angle_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed and randomly-handshaked stimulus for cordic_vectoring, checked
// against hand-derived values and an ideal atan2/magnitude model with tolerance.
module tb_cordic_vectoring;

    localparam int  W     = 16;
    localparam int  ITER  = 13;
    localparam int  IW    = 18;
    localparam real PI    = 3.14159265358979;
    localparam real KGAIN = 1.646760258;
    localparam int  NSTREAM = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x_in;
    logic [W-1:0]  y_in;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] mag_out;
    logic [IW-1:0] angle_out;

    int n_cmp = 0;
    int n_bad = 0;
    int qx[$];
    int qy[$];

    cordic_vectoring #(.W(W), .ITER(ITER), .IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .angle_out (angle_out)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        longint d;
        n_cmp++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint ang_s();
        return longint'($signed(angle_out));
    endfunction

    function automatic longint mag_s();
        return longint'($signed(mag_out));
    endfunction

    function automatic longint ideal_ang(input int x, input int y);
        real a;
        a = $atan2(real'(y), real'(x)) * 180.0 / PI * 256.0;
        return longint'(a);
    endfunction

    function automatic longint ideal_mag(input int x, input int y);
        real m;
        m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * KGAIN;
        return longint'(m);
    endfunction

    task automatic send(input string tag, input int x, input int y);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        check({tag, "_ready"}, longint'(in_ready), 1, 0);
        x_in     = W'(x);
        y_in     = W'(y);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 50);
    endtask

    task automatic run_vec(input string tag, input int x, input int y,
                           input longint ea, input longint ta,
                           input longint em, input longint tm);
        int lat;
        send(tag, x, y);
        wait_out(lat);
        check({tag, "_lat"}, lat, ITER, 0);
        check({tag, "_ang"}, ang_s(), ea, ta);
        check({tag, "_mag"}, mag_s(), em, tm);
        $display("vec %s (%0d,%0d): lat=%0d angle=%0d mag=%0d", tag, x, y, lat, ang_s(), mag_s());
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_consumed"}, longint'(out_valid), 0, 0);
        check({tag, "_idle"}, longint'(in_ready), 1, 0);
    endtask

    // Directed vectors: x, y, expected angle, angle tol, expected mag, mag tol
    string  d_tag [11] = '{"pos_x", "pos_y", "neg_y", "q1", "q2", "q3", "q4",
                           "neg_x", "neg_x_m1", "min_min", "zero"};
    int     d_x   [11] = '{256, 0, 0, 256, -256, -256, 256, -256, -256, -32768, 0};
    int     d_y   [11] = '{0, 256, -256, 256, 256, -256, -256, 0, -1, -32768, 0};
    longint d_ea  [11] = '{0, 23040, -23040, 11520, 34560, -34560, -11520, 46080, -46023, -34560, 0};
    longint d_ta  [11] = '{64, 64, 64, 64, 64, 64, 64, 64, 64, 64, 0};
    longint d_em  [11] = '{421, 421, 421, 596, 596, 596, 596, 421, 421, 76313, 0};
    longint d_tm  [11] = '{8, 8, 8, 8, 8, 8, 8, 8, 8, 84, 0};

    initial begin
        int lat;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        repeat (3) tick();
        check("rst_in_ready", longint'(in_ready), 0, 0);
        rst = 1'b0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0, 0);
        check("rst_mag", mag_s(), 0, 0);
        check("rst_angle", ang_s(), 0, 0);
        check("rst_in_ready_after", longint'(in_ready), 1, 0);
        $display("reset: out_valid=%0d mag=%0d angle=%0d in_ready=%0d", out_valid, mag_s(), ang_s(), in_ready);

        // Abort an in-flight vector with a mid-iteration reset
        send("abort", 100, 100);
        repeat (4) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("abort_in_ready_rst", longint'(in_ready), 0, 0);
        rst = 1'b0;
        #1;
        check("abort_out_valid", longint'(out_valid), 0, 0);
        check("abort_mag", mag_s(), 0, 0);
        check("abort_angle", ang_s(), 0, 0);
        check("abort_in_ready", longint'(in_ready), 1, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_output", seen, 0, 0);
        $display("abort: reset mid-iteration, output cycles seen=%0d", seen);

        for (int i = 0; i < 11; i++)
            run_vec(d_tag[i], d_x[i], d_y[i], d_ea[i], d_ta[i], d_em[i], d_tm[i]);

        // Backpressure: result must hold while out_ready is low
        send("hold", 256, 256);
        wait_out(lat);
        check("hold_lat", lat, ITER, 0);
        in_valid = 1'b1;
        x_in     = W'(1234);
        y_in     = W'(-999);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", longint'(out_valid), 1, 0);
            check("hold_in_ready", longint'(in_ready), 0, 0);
            check("hold_ang", ang_s(), 11520, 64);
            check("hold_mag", mag_s(), 596, 8);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_release_valid", longint'(out_valid), 0, 0);
        check("hold_release_ready", longint'(in_ready), 1, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("hold_no_extra", seen, 0, 0);
        $display("hold: angle=%0d mag=%0d after 10 stalled cycles, extra outputs=%0d", ang_s(), mag_s(), seen);

        // Streaming with random handshakes on both sides
        fork
            begin
                int  sent;
                int  guard;
                int  vx;
                int  vy;
                bit  acc;
                bit  need;
                sent  = 0;
                guard = 0;
                need  = 1'b1;
                vx    = 0;
                vy    = 0;
                while (sent < NSTREAM && guard < 20000) begin
                    if (need) begin
                        do begin
                            vx = int'($urandom_range(0, 65535)) - 32768;
                            vy = int'($urandom_range(0, 65535)) - 32768;
                        end while (longint'(vx) * vx + longint'(vy) * vy < 64'd4194304);
                        need = 1'b0;
                    end
                    in_valid = 1'($urandom_range(0, 1));
                    if (in_valid) begin
                        x_in = W'(vx);
                        y_in = W'(vy);
                    end else begin
                        x_in = W'($urandom);
                        y_in = W'($urandom);
                    end
                    acc = in_valid && in_ready;
                    tick();
                    guard++;
                    if (acc) begin
                        qx.push_back(vx);
                        qy.push_back(vy);
                        sent++;
                        need = 1'b1;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                int     got;
                int     guard;
                int     ex;
                int     ey;
                longint ea;
                longint em;
                got   = 0;
                guard = 0;
                while (got < NSTREAM && guard < 20000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        if (qx.size() == 0) begin
                            check("stream_unexpected", 1, 0, 0);
                        end else begin
                            ex = qx.pop_front();
                            ey = qy.pop_front();
                            ea = ideal_ang(ex, ey);
                            em = ideal_mag(ex, ey);
                            if (ea - ang_s() > 46080) ea -= 92160;
                            if (ang_s() - ea > 46080) ea += 92160;
                            check("stream_ang", ang_s(), ea, 64);
                            check("stream_mag", mag_s(), em, 14 + em / 1000);
                            $display("stream #%0d (%0d,%0d): angle=%0d ref=%0d mag=%0d ref=%0d",
                                     got, ex, ey, ang_s(), ea, mag_s(), em);
                        end
                        got++;
                    end
                    tick();
                    guard++;
                end
                out_ready = 1'b0;
                check("stream_count", got, NSTREAM, 0);
            end
        join
        check("stream_leftover", qx.size(), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
